iso7816_trigger_shaper: RTL and testbench

Downstream stage of the ISO7816 APDU pattern matcher. It takes the matcher's level-type match output, detects its rising edge, and produces a clean scope/glitcher trigger pulse of programmable delay and width. Once armed it enforces a holdoff and a maximum fire count, and reports fired and missed events. It runs entirely in the CARD_CLK domain, so TRIG_IN needs no synchronizer.

---
 rtl/iso7816_trigger_shaper_if.sv | 26 ++
 rtl/iso7816_trigger_shaper.sv | 146 ++++++++++++++
 tb/tb_iso7816_trigger_shaper.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/iso7816_trigger_shaper_if.sv
// Trigger shaper control/status bundle.
// Arming and match input in, pulse and counters out.
interface iso7816_trigger_shaper_if #(
  parameter int COUNT_WIDTH = 8
);
  logic                   ARM;
  logic                   TRIG_IN;
  logic                   TRIG_OUT;
  logic                   ARMED;
  logic                   BUSY;
  logic                   DONE;
  logic [COUNT_WIDTH-1:0] FIRE_COUNT;
  logic [COUNT_WIDTH-1:0] MISSED_COUNT;

  modport master (
    output ARM, TRIG_IN,
    input  TRIG_OUT, ARMED, BUSY, DONE,
    input  FIRE_COUNT, MISSED_COUNT
  );

  modport slave (
    input  ARM, TRIG_IN,
    output TRIG_OUT, ARMED, BUSY, DONE,
    output FIRE_COUNT, MISSED_COUNT
  );
endinterface

// File: rtl/iso7816_trigger_shaper.sv
// Shapes the APDU matcher's match level into a delayed,
// fixed-width trigger pulse with holdoff and fire limiting.
module iso7816_trigger_shaper #(
  parameter int DELAY_CLKS   = 0,
  parameter int PULSE_CLKS   = 16,
  parameter int HOLDOFF_CLKS = 372,
  parameter int MAX_FIRES    = 1,
  parameter int COUNT_WIDTH  = 8
) (
  input logic CARD_CLK,
  input logic RESET_N,
  iso7816_trigger_shaper_if.slave bus
);

  localparam int M1 =
    DELAY_CLKS > PULSE_CLKS ? DELAY_CLKS : PULSE_CLKS;
  localparam int MX =
    M1 > HOLDOFF_CLKS ? M1 : HOLDOFF_CLKS;
  localparam int CW =
    $clog2(MX + 1) < 1 ? 1 : $clog2(MX + 1);

  localparam logic [CW-1:0] DLY_LD =
    CW'(DELAY_CLKS == 0 ? 0 : DELAY_CLKS - 1);
  localparam logic [CW-1:0] PLS_LD =
    CW'(PULSE_CLKS == 0 ? 0 : PULSE_CLKS - 1);
  localparam logic [CW-1:0] HLD_LD =
    CW'(HOLDOFF_CLKS == 0 ? 0 : HOLDOFF_CLKS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DELAY,
    S_PULSE,
    S_HOLD,
    S_DONE
  } state_t;

  typedef logic [COUNT_WIDTH-1:0] cnt_t;

  state_t          state_q, state_d;
  logic            prev_q;
  logic [CW-1:0]   tmr_q, tmr_d;
  cnt_t            fire_q, fire_d;
  cnt_t            miss_q, miss_d;
  cnt_t            fire_inc;
  logic            trig_edge;

  function automatic cnt_t sat_inc(input cnt_t v);
    return (v == '1) ? v : v + COUNT_WIDTH'(1);
  endfunction

  function automatic state_t rearm(input cnt_t f);
    if (MAX_FIRES != 0 && int'(f) >= MAX_FIRES)
      return S_DONE;
    return S_WAIT;
  endfunction

  assign trig_edge = bus.TRIG_IN & ~prev_q;
  assign fire_inc  = sat_inc(fire_q);

  always_ff @(posedge CARD_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= S_IDLE;
      prev_q  <= 1'b1;
      tmr_q   <= '0;
      fire_q  <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      prev_q  <= bus.TRIG_IN;
      tmr_q   <= tmr_d;
      fire_q  <= fire_d;
      miss_q  <= miss_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    fire_d  = fire_q;
    miss_d  = miss_q;
    if (!bus.ARM) begin
      state_d = S_IDLE;
    end else begin
      if (trig_edge && state_q inside
          {S_DELAY, S_PULSE, S_HOLD, S_DONE})
        miss_d = sat_inc(miss_q);
      unique case (state_q)
        S_IDLE: begin
          state_d = S_WAIT;
          fire_d  = '0;
          miss_d  = '0;
        end
        S_WAIT: begin
          if (trig_edge) begin
            if (DELAY_CLKS == 0) begin
              state_d = S_PULSE;
              tmr_d   = PLS_LD;
            end else begin
              state_d = S_DELAY;
              tmr_d   = DLY_LD;
            end
          end
        end
        S_DELAY: begin
          if (tmr_q == '0) begin
            state_d = S_PULSE;
            tmr_d   = PLS_LD;
          end else begin
            tmr_d = tmr_q - CW'(1);
          end
        end
        S_PULSE: begin
          if (tmr_q == '0) begin
            fire_d = fire_inc;
            if (HOLDOFF_CLKS > 0) begin
              state_d = S_HOLD;
              tmr_d   = HLD_LD;
            end else begin
              state_d = rearm(fire_inc);
            end
          end else begin
            tmr_d = tmr_q - CW'(1);
          end
        end
        S_HOLD: begin
          if (tmr_q == '0)
            state_d = rearm(fire_q);
          else
            tmr_d = tmr_q - CW'(1);
        end
        S_DONE: state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign bus.TRIG_OUT     = (state_q == S_PULSE);
  assign bus.ARMED        = (state_q == S_WAIT);
  assign bus.BUSY         = state_q inside
                            {S_DELAY, S_PULSE, S_HOLD};
  assign bus.DONE         = (state_q == S_DONE);
  assign bus.FIRE_COUNT   = fire_q;
  assign bus.MISSED_COUNT = miss_q;

endmodule

// File: tb/tb_iso7816_trigger_shaper.sv
// Directed bench for iso7816_trigger_shaper over four
// parameter sets sharing one CARD_CLK.
module tb_iso7816_trigger_shaper;

  logic clk = 1'b0;
  logic rst0, rst1, rst2, rst3;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  iso7816_trigger_shaper_if #(.COUNT_WIDTH(8)) b0 ();
  iso7816_trigger_shaper_if #(.COUNT_WIDTH(8)) b1 ();
  iso7816_trigger_shaper_if #(.COUNT_WIDTH(8)) b2 ();
  iso7816_trigger_shaper_if #(.COUNT_WIDTH(2)) b3 ();

  iso7816_trigger_shaper dut0 (
    .CARD_CLK(clk), .RESET_N(rst0), .bus(b0));

  iso7816_trigger_shaper #(
    .DELAY_CLKS(5), .PULSE_CLKS(3),
    .HOLDOFF_CLKS(0), .MAX_FIRES(1)
  ) dut1 (.CARD_CLK(clk), .RESET_N(rst1), .bus(b1));

  iso7816_trigger_shaper #(
    .HOLDOFF_CLKS(10), .MAX_FIRES(0)
  ) dut2 (.CARD_CLK(clk), .RESET_N(rst2), .bus(b2));

  iso7816_trigger_shaper #(
    .PULSE_CLKS(2), .HOLDOFF_CLKS(2),
    .MAX_FIRES(1), .COUNT_WIDTH(2)
  ) dut3 (.CARD_CLK(clk), .RESET_N(rst3), .bus(b3));

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    b0.ARM = 0; b0.TRIG_IN = 1;
    b1.ARM = 0; b1.TRIG_IN = 0;
    b2.ARM = 0; b2.TRIG_IN = 0;
    b3.ARM = 0; b3.TRIG_IN = 0;
    rst0 = 0; rst1 = 0; rst2 = 0; rst3 = 0;
    step(3);
    n_cmp++;
    if ({b0.TRIG_OUT, b0.ARMED, b0.BUSY, b0.DONE} !== 4'b0) begin
      n_err++;
      $display("FAIL reset_flags: got %b want 0000",
        {b0.TRIG_OUT, b0.ARMED, b0.BUSY, b0.DONE});
    end
    n_cmp++;
    if (b0.FIRE_COUNT !== 8'd0 || b0.MISSED_COUNT !== 8'd0) begin
      n_err++;
      $display("FAIL reset_counts: got %0d/%0d want 0/0",
        b0.FIRE_COUNT, b0.MISSED_COUNT);
    end
    rst0 = 1; rst1 = 1; rst2 = 1; rst3 = 1;
  endtask

  task automatic test_default_fire;
    int hi;
    b0.ARM = 1;
    step(1);
    n_cmp++;
    if (b0.ARMED !== 1'b1) begin
      n_err++;
      $display("FAIL arm_latency: ARMED got %b want 1", b0.ARMED);
    end
    step(3);
    n_cmp++;
    if (b0.TRIG_OUT !== 1'b0 || b0.MISSED_COUNT !== 8'd0) begin
      n_err++;
      $display("FAIL high_from_reset: trig %b missed %0d want 0/0",
        b0.TRIG_OUT, b0.MISSED_COUNT);
    end
    b0.TRIG_IN = 0;
    step(1);
    b0.TRIG_IN = 1;
    step(1);
    hi = 0;
    for (int i = 0; i < 16; i++) begin
      if (b0.TRIG_OUT === 1'b1) hi++;
      if (i < 15) step(1);
    end
    n_cmp++;
    if (hi !== 16) begin
      n_err++;
      $display("FAIL default_width: high cycles got %0d want 16", hi);
    end
    step(1);
    n_cmp++;
    if (b0.TRIG_OUT !== 1'b0 || b0.FIRE_COUNT !== 8'd1
        || b0.BUSY !== 1'b1) begin
      n_err++;
      $display("FAIL default_end: trig %b fire %0d busy %b want 0/1/1",
        b0.TRIG_OUT, b0.FIRE_COUNT, b0.BUSY);
    end
    step(371);
    n_cmp++;
    if (b0.DONE !== 1'b0 || b0.BUSY !== 1'b1) begin
      n_err++;
      $display("FAIL holdoff_len: done %b busy %b want 0/1",
        b0.DONE, b0.BUSY);
    end
    step(1);
    n_cmp++;
    if (b0.DONE !== 1'b1 || b0.ARMED !== 1'b0) begin
      n_err++;
      $display("FAIL default_done: done %b armed %b want 1/0",
        b0.DONE, b0.ARMED);
    end
  endtask

  task automatic test_abort;
    b0.ARM = 0;
    step(1);
    n_cmp++;
    if (b0.DONE !== 1'b0 || b0.FIRE_COUNT !== 8'd1) begin
      n_err++;
      $display("FAIL disarm: done %b fire %0d want 0/1",
        b0.DONE, b0.FIRE_COUNT);
    end
    b0.ARM = 1;
    step(1);
    n_cmp++;
    if (b0.ARMED !== 1'b1 || b0.FIRE_COUNT !== 8'd0) begin
      n_err++;
      $display("FAIL rearm_clear: armed %b fire %0d want 1/0",
        b0.ARMED, b0.FIRE_COUNT);
    end
    b0.TRIG_IN = 0;
    step(1);
    b0.TRIG_IN = 1;
    step(1);
    b0.TRIG_IN = 0;
    step(1);
    b0.TRIG_IN = 1;
    step(1);
    step(2);
    n_cmp++;
    if (b0.TRIG_OUT !== 1'b1 || b0.MISSED_COUNT !== 8'd1) begin
      n_err++;
      $display("FAIL pulse_miss: trig %b missed %0d want 1/1",
        b0.TRIG_OUT, b0.MISSED_COUNT);
    end
    b0.ARM = 0;
    step(1);
    n_cmp++;
    if (b0.TRIG_OUT !== 1'b0 || b0.BUSY !== 1'b0
        || b0.FIRE_COUNT !== 8'd0 || b0.MISSED_COUNT !== 8'd1) begin
      n_err++;
      $display("FAIL abort: trig %b busy %b fire %0d miss %0d want 0/0/0/1",
        b0.TRIG_OUT, b0.BUSY, b0.FIRE_COUNT, b0.MISSED_COUNT);
    end
    b0.ARM = 1;
    step(1);
    n_cmp++;
    if (b0.MISSED_COUNT !== 8'd0 || b0.ARMED !== 1'b1) begin
      n_err++;
      $display("FAIL rearm_miss_clear: miss %0d armed %b want 0/1",
        b0.MISSED_COUNT, b0.ARMED);
    end
  endtask

  task automatic test_delay;
    logic [8:0] seen;
    b1.ARM = 1;
    step(1);
    b1.TRIG_IN = 1;
    step(1);
    seen = '0;
    for (int i = 0; i < 9; i++) begin
      seen[i] = b1.TRIG_OUT;
      if (i < 8) step(1);
    end
    n_cmp++;
    if (seen !== 9'b011100000) begin
      n_err++;
      $display("FAIL delay_window: E+8..E got %b want 011100000", seen);
    end
    n_cmp++;
    if (b1.DONE !== 1'b1 || b1.FIRE_COUNT !== 8'd1) begin
      n_err++;
      $display("FAIL delay_done: done %b fire %0d want 1/1",
        b1.DONE, b1.FIRE_COUNT);
    end
  endtask

  task automatic test_async_reset;
    int hi;
    b1.ARM = 0;
    step(1);
    b1.ARM = 1;
    b1.TRIG_IN = 0;
    step(1);
    b1.TRIG_IN = 1;
    step(1);
    step(2);
    #3;
    rst1 = 0;
    #1;
    n_cmp++;
    if ({b1.TRIG_OUT, b1.ARMED, b1.BUSY, b1.DONE} !== 4'b0) begin
      n_err++;
      $display("FAIL async_reset: flags %b want 0000",
        {b1.TRIG_OUT, b1.ARMED, b1.BUSY, b1.DONE});
    end
    #1;
    rst1 = 1;
    hi = 0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      if (b1.TRIG_OUT === 1'b1) hi++;
    end
    n_cmp++;
    if (hi !== 0 || b1.ARMED !== 1'b1) begin
      n_err++;
      $display("FAIL post_reset: pulses %0d armed %b want 0/1",
        hi, b1.ARMED);
    end
  endtask

  task automatic test_multi_fire;
    int rises, highs;
    logic last;
    b2.ARM = 1;
    step(1);
    rises = 0; highs = 0; last = 0;
    for (int c = 0; c < 120; c++) begin
      b2.TRIG_IN = (c == 0 || c == 20 || c == 40 || c == 80);
      step(1);
      if (b2.TRIG_OUT === 1'b1) highs++;
      if (b2.TRIG_OUT === 1'b1 && !last) rises++;
      last = b2.TRIG_OUT;
    end
    n_cmp++;
    if (rises !== 3 || highs !== 48) begin
      n_err++;
      $display("FAIL multi_pulses: rises %0d highs %0d want 3/48",
        rises, highs);
    end
    n_cmp++;
    if (b2.FIRE_COUNT !== 8'd3 || b2.MISSED_COUNT !== 8'd1) begin
      n_err++;
      $display("FAIL multi_counts: fire %0d miss %0d want 3/1",
        b2.FIRE_COUNT, b2.MISSED_COUNT);
    end
    b2.ARM = 0;
    b2.TRIG_IN = 1;
    step(1);
    n_cmp++;
    if (b2.TRIG_OUT !== 1'b0 || b2.ARMED !== 1'b0
        || b2.FIRE_COUNT !== 8'd3 || b2.MISSED_COUNT !== 8'd1) begin
      n_err++;
      $display("FAIL arm_vs_edge: trig %b armed %b fire %0d miss %0d",
        b2.TRIG_OUT, b2.ARMED, b2.FIRE_COUNT, b2.MISSED_COUNT);
    end
  endtask

  task automatic test_saturate;
    int w;
    b3.ARM = 1;
    step(1);
    b3.TRIG_IN = 1;
    step(1);
    b3.TRIG_IN = 0;
    w = 0;
    while (b3.DONE !== 1'b1 && w < 20) begin
      step(1);
      w++;
    end
    n_cmp++;
    if (b3.DONE !== 1'b1) begin
      n_err++;
      $display("FAIL sat_done_timeout: done %b want 1", b3.DONE);
    end
    for (int k = 0; k < 6; k++) begin
      b3.TRIG_IN = 1;
      step(1);
      b3.TRIG_IN = 0;
      step(1);
      if (k == 2) begin
        n_cmp++;
        if (b3.MISSED_COUNT !== 2'd3) begin
          n_err++;
          $display("FAIL sat_three: miss %0d want 3", b3.MISSED_COUNT);
        end
      end
    end
    n_cmp++;
    if (b3.MISSED_COUNT !== 2'd3 || b3.FIRE_COUNT !== 2'd1) begin
      n_err++;
      $display("FAIL sat_six: miss %0d fire %0d want 3/1",
        b3.MISSED_COUNT, b3.FIRE_COUNT);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_default_fire();
    test_abort();
    test_delay();
    test_async_reset();
    test_multi_fire();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
      n_cmp, n_err);
    $finish;
  end

endmodule
